// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-rate divider, h/v counters and
// registered sync/bright/strobe outputs, all aligned to the presented position.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int PIX_DIV   = 2,
  parameter int CNT_W     = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic             hsync,
  output logic             vsync,
  output logic             bright,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             pix_tick,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic             HS_ON    = 1'(HSYNC_POL);
  localparam logic             VS_ON    = 1'(VSYNC_POL);

  if (((64'd1 << CNT_W) < 64'(H_TOTAL)) || ((64'd1 << CNT_W) < 64'(V_TOTAL)) ||
      (PIX_DIV < 1)) begin : g_param_check
    $error("vga_timing_gen: CNT_W cannot hold the raster totals or PIX_DIV < 1");
  end

  function automatic logic f_in_range(input logic [CNT_W-1:0] pos, input int lo, input int hi);
    return (int'(pos) >= lo) && (int'(pos) < hi);
  endfunction

  function automatic logic f_hsync(input logic [CNT_W-1:0] h);
    return f_in_range(h, HS_START, HS_END) ? HS_ON : ~HS_ON;
  endfunction

  function automatic logic f_vsync(input logic [CNT_W-1:0] v);
    return f_in_range(v, VS_START, VS_END) ? VS_ON : ~VS_ON;
  endfunction

  function automatic logic f_bright(input logic [CNT_W-1:0] h, input logic [CNT_W-1:0] v);
    return f_in_range(h, 0, H_VISIBLE) && f_in_range(v, 0, V_VISIBLE);
  endfunction

  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_h, r_v;
  logic             r_hs, r_vs, r_br;
  logic             r_pt, r_ls, r_fs;

  logic             w_adv;
  logic [CNT_W-1:0] w_h_next, w_v_next;

  assign w_adv    = enable && (r_div == DIV_LAST);
  assign w_h_next = (r_h == H_LAST) ? '0 : r_h + CNT_W'(1);
  assign w_v_next = (r_h != H_LAST) ? r_v :
                    (r_v == V_LAST) ? '0  : r_v + CNT_W'(1);

  // Decode is taken from the next position so sync/bright land on the same edge as the counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= '0;
      r_h   <= '0;
      r_v   <= '0;
      r_hs  <= f_hsync('0);
      r_vs  <= f_vsync('0);
      r_br  <= f_bright('0, '0);
      r_pt  <= 1'b0;
      r_ls  <= 1'b0;
      r_fs  <= 1'b0;
    end else begin
      r_pt <= 1'b0;
      r_ls <= 1'b0;
      r_fs <= 1'b0;
      if (enable) begin
        r_div <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
      end
      if (w_adv) begin
        r_h  <= w_h_next;
        r_v  <= w_v_next;
        r_hs <= f_hsync(w_h_next);
        r_vs <= f_vsync(w_v_next);
        r_br <= f_bright(w_h_next, w_v_next);
        r_pt <= 1'b1;
        r_ls <= (w_h_next == '0);
        r_fs <= (w_h_next == '0) && (w_v_next == '0);
      end
    end
  end

  assign hsync       = r_hs;
  assign vsync       = r_vs;
  assign bright      = r_br;
  assign hcount      = r_h;
  assign vcount      = r_v;
  assign pix_tick    = r_pt;
  assign line_start  = r_ls;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a full-size 640x480 instance plus two small-raster
// instances (PIX_DIV 1 and 2), each compared every clk against a queued expected state.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;

  always #5 clk = ~clk;

  logic       a_hsync, a_vsync, a_bright, a_pix_tick, a_line_start, a_frame_start;
  logic [9:0] a_hcount, a_vcount;
  logic       b_hsync, b_vsync, b_bright, b_pix_tick, b_line_start, b_frame_start;
  logic [9:0] b_hcount, b_vcount;
  logic       c_hsync, c_vsync, c_bright, c_pix_tick, c_line_start, c_frame_start;
  logic [9:0] c_hcount, c_vcount;

  vga_timing_gen #(.PIX_DIV(1)) u_a (
    .clk(clk), .reset(reset), .enable(enable),
    .hsync(a_hsync), .vsync(a_vsync), .bright(a_bright),
    .hcount(a_hcount), .vcount(a_vcount),
    .pix_tick(a_pix_tick), .line_start(a_line_start), .frame_start(a_frame_start)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2),
    .HSYNC_POL(1), .VSYNC_POL(1), .PIX_DIV(1), .CNT_W(10)
  ) u_b (
    .clk(clk), .reset(reset), .enable(enable),
    .hsync(b_hsync), .vsync(b_vsync), .bright(b_bright),
    .hcount(b_hcount), .vcount(b_vcount),
    .pix_tick(b_pix_tick), .line_start(b_line_start), .frame_start(b_frame_start)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2),
    .HSYNC_POL(1), .VSYNC_POL(1), .PIX_DIV(2), .CNT_W(10)
  ) u_c (
    .clk(clk), .reset(reset), .enable(enable),
    .hsync(c_hsync), .vsync(c_vsync), .bright(c_bright),
    .hcount(c_hcount), .vcount(c_vcount),
    .pix_tick(c_pix_tick), .line_start(c_line_start), .frame_start(c_frame_start)
  );

  logic [31:0] a_obs, b_obs, c_obs;
  assign a_obs = {3'b000, a_hsync, a_vsync, a_bright, a_hcount, a_vcount,
                  a_pix_tick, a_line_start, a_frame_start};
  assign b_obs = {3'b000, b_hsync, b_vsync, b_bright, b_hcount, b_vcount,
                  b_pix_tick, b_line_start, b_frame_start};
  assign c_obs = {3'b000, c_hsync, c_vsync, c_bright, c_hcount, c_vcount,
                  c_pix_tick, c_line_start, c_frame_start};

  int          n_checks = 0;
  int          n_err    = 0;
  longint      k        = 0;   // enabled clk edges since last reset
  longint      last_fs_b = -1;
  longint      last_fs_c = -1;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] qc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs after the k-th enabled edge: pixel index is k/n, position is its
  // row-major decomposition over the raster totals.
  function automatic logic [31:0] model(input longint kk, input bit adv, input int n,
                                        input int hv, input int hf, input int hs, input int hb,
                                        input int vv, input int vf, input int vs, input int vb,
                                        input bit hp, input bit vp);
    int     ht, vt, h, v;
    longint p;
    logic   hso, vso, br, ls, fs;
    ht  = hv + hf + hs + hb;
    vt  = vv + vf + vs + vb;
    p   = kk / longint'(n);
    h   = int'(p % longint'(ht));
    v   = int'((p / longint'(ht)) % longint'(vt));
    hso = (h >= hv + hf && h < hv + hf + hs) ? hp : ~hp;
    vso = (v >= vv + vf && v < vv + vf + vs) ? vp : ~vp;
    br  = (h < hv) && (v < vv);
    ls  = adv && (h == 0);
    fs  = ls && (v == 0);
    return {3'b000, hso, vso, br, h[9:0], v[9:0], adv, ls, fs};
  endfunction

  task automatic tick(input bit rst, input bit en);
    bit adv1, adv2;
    reset  = rst;
    enable = en;
    adv1 = 1'b0;
    adv2 = 1'b0;
    if (rst) begin
      k = 0;
    end else if (en) begin
      k++;
      adv1 = 1'b1;
      adv2 = (k % 2 == 0);
    end
    qa.push_back(model(k, adv1, 1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0));
    qb.push_back(model(k, adv1, 1, 8, 2, 3, 3, 4, 1, 1, 2, 1'b1, 1'b1));
    qc.push_back(model(k, adv2, 2, 8, 2, 3, 3, 4, 1, 1, 2, 1'b1, 1'b1));
    @(posedge clk);
    #1;
    chk("sb_full", a_obs, qa.pop_front());
    chk("sb_small_div1", b_obs, qb.pop_front());
    chk("sb_small_div2", c_obs, qc.pop_front());
    if (rst) begin
      last_fs_b = -1;
      last_fs_c = -1;
    end
    if (b_frame_start) begin
      if (last_fs_b < 0) chk("b_first_frame", 32'(k), 32'd128);
      else               chk("b_frame_period", 32'(k - last_fs_b), 32'd128);
      last_fs_b = k;
    end
    if (c_frame_start) begin
      if (last_fs_c < 0) chk("c_first_frame", 32'(k), 32'd256);
      else               chk("c_frame_period", 32'(k - last_fs_c), 32'd256);
      last_fs_c = k;
    end
  endtask

  initial begin
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    chk("rst_hcount", 32'(a_hcount), 32'd0);
    chk("rst_vcount", 32'(a_vcount), 32'd0);
    chk("rst_bright", 32'(a_bright), 32'd1);
    chk("rst_hsync", 32'(a_hsync), 32'd1);
    chk("rst_vsync", 32'(a_vsync), 32'd1);
    chk("rst_strobes", {29'd0, a_pix_tick, a_line_start, a_frame_start}, 32'd0);

    repeat (639) tick(1'b0, 1'b1);
    chk("bright_639", 32'(a_bright), 32'd1);
    tick(1'b0, 1'b1);
    chk("bright_640", 32'(a_bright), 32'd0);
    chk("hcount_640", 32'(a_hcount), 32'd640);
    repeat (15) tick(1'b0, 1'b1);
    chk("hsync_655", {a_hcount, 21'd0, a_hsync}, {10'd655, 21'd0, 1'b1});
    tick(1'b0, 1'b1);
    chk("hsync_656", {a_hcount, 21'd0, a_hsync}, {10'd656, 21'd0, 1'b0});
    repeat (95) tick(1'b0, 1'b1);
    chk("hsync_751", {a_hcount, 21'd0, a_hsync}, {10'd751, 21'd0, 1'b0});
    tick(1'b0, 1'b1);
    chk("hsync_752", {a_hcount, 21'd0, a_hsync}, {10'd752, 21'd0, 1'b1});
    repeat (47) tick(1'b0, 1'b1);
    chk("pos_799", {22'd0, a_hcount}, 32'd799);
    tick(1'b0, 1'b1);
    chk("wrap_hcount", 32'(a_hcount), 32'd0);
    chk("wrap_vcount", 32'(a_vcount), 32'd1);
    chk("wrap_line_start", 32'(a_line_start), 32'd1);
    chk("wrap_frame_start", 32'(a_frame_start), 32'd0);

    repeat (300) tick(1'b0, 1'b1);
    chk("pre_pause_hcount", 32'(a_hcount), 32'd300);
    repeat (7) tick(1'b0, 1'b0);
    chk("pause_hcount", 32'(a_hcount), 32'd300);
    chk("pause_strobes", {29'd0, a_pix_tick, b_pix_tick, c_pix_tick}, 32'd0);
    tick(1'b0, 1'b1);
    chk("resume_hcount", 32'(a_hcount), 32'd301);

    repeat (199) tick(1'b0, 1'b1);
    chk("pre_reset_hcount", 32'(a_hcount), 32'd500);
    tick(1'b1, 1'b1);
    chk("midrst_pos", {12'd0, a_hcount, a_vcount}, 32'd0);
    chk("midrst_flags", {29'd0, a_bright, a_hsync, a_vsync}, 32'd7);
    chk("midrst_strobes", {29'd0, a_pix_tick, a_line_start, a_frame_start}, 32'd0);

    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b1);
      chk("c_pix_tick_phase", 32'(c_pix_tick), 32'(i % 2));
    end
    repeat (600) tick(1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
